pwm_deadtime_output: RTL and testbench

Parametrised multi-channel complementary PWM generator with dead-time insertion, edge- or center-aligned counting, synchronous enable and glitch-free duty/dead-time/mode updates at period boundaries. All channels share one period counter and drive half-bridge gate pairs (outh/outl) for motor and power-stage control. The block sits between the control-loop duty outputs and the board gate-driver pins.

---
 rtl/pwm_deadtime_output.sv | 190 +++++++++++++++++++
 tb/tb_pwm_deadtime_output.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_output.sv
// Multi-channel complementary PWM with dead-time insertion. One shared period
// counter (sawtooth or triangle); duty, dead time and mode latch only at count zero.
module pwm_deadtime_output #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int DT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] set,
  input  logic [DT_WIDTH-1:0]       deadtime,
  output logic [CHANNELS-1:0]       outh,
  output logic [CHANNELS-1:0]       outl,
  output logic                      period_start
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_LOW    = 3'd1,
    ST_DEAD_R = 3'd2,
    ST_HIGH   = 3'd3,
    ST_DEAD_F = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]    CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]    CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]    CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [DT_WIDTH-1:0] DT_ZERO  = {DT_WIDTH{1'b0}};
  localparam logic [DT_WIDTH-1:0] DT_ONE   = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    count_r;
  logic                dir_r;
  logic                mode_r;
  logic [DT_WIDTH-1:0] dt_goal_r;
  logic [WIDTH-1:0]    goal_r [CHANNELS];
  state_t              state_r [CHANNELS];
  logic [DT_WIDTH-1:0] dtc_r [CHANNELS];
  logic [CHANNELS-1:0] raw_s;
  logic                at_zero_s;

  assign at_zero_s = (count_r == CNT_ZERO);

  // Shared period counter: sawtooth in edge mode, 0..max..1 triangle in center mode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= CNT_ZERO;
      dir_r   <= 1'b1;
    end else if (!enable) begin
      count_r <= CNT_ZERO;
      dir_r   <= 1'b1;
    end else if (!mode_r) begin
      count_r <= count_r + CNT_ONE;
      dir_r   <= 1'b1;
    end else if (dir_r || at_zero_s) begin
      if (count_r == CNT_MAX) begin
        count_r <= CNT_MAX - CNT_ONE;
        dir_r   <= 1'b0;
      end else begin
        count_r <= count_r + CNT_ONE;
        dir_r   <= 1'b1;
      end
    end else begin
      count_r <= count_r - CNT_ONE;
      dir_r   <= (count_r == CNT_ONE);
    end
  end

  // Shadow registers; also reloaded every cycle while disabled since count sits at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dt_goal_r    <= DT_ZERO;
      mode_r       <= 1'b0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) goal_r[i] <= CNT_ZERO;
    end else begin
      period_start <= enable && at_zero_s;
      if (at_zero_s) begin
        dt_goal_r <= deadtime;
        mode_r    <= center_mode;
        for (int i = 0; i < CHANNELS; i++) goal_r[i] <= set[i*WIDTH +: WIDTH];
      end else begin
        dt_goal_r <= dt_goal_r;
        mode_r    <= mode_r;
      end
    end
  end

  // Per-channel demand compare
  always_comb begin
    raw_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) raw_s[i] = (count_r < goal_r[i]);
  end

  // Per-channel gate FSM; outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outh <= {CHANNELS{1'b0}};
      outl <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= ST_OFF;
        dtc_r[i]   <= DT_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!enable) begin
          state_r[i] <= ST_OFF;
          outh[i]    <= 1'b0;
          outl[i]    <= 1'b0;
        end else begin
          case (state_r[i])
            ST_OFF: begin
              state_r[i] <= ST_LOW;
              outh[i]    <= 1'b0;
              outl[i]    <= 1'b1;
            end
            ST_LOW: begin
              if (raw_s[i] && dt_goal_r == DT_ZERO) begin
                state_r[i] <= ST_HIGH;
                outh[i]    <= 1'b1;
                outl[i]    <= 1'b0;
              end else if (raw_s[i]) begin
                state_r[i] <= ST_DEAD_R;
                dtc_r[i]   <= dt_goal_r - DT_ONE;
                outh[i]    <= 1'b0;
                outl[i]    <= 1'b0;
              end else begin
                outh[i] <= 1'b0;
                outl[i] <= 1'b1;
              end
            end
            ST_DEAD_R: begin
              // A demand pulse shorter than the dead time is swallowed here
              if (!raw_s[i]) begin
                state_r[i] <= ST_LOW;
                outh[i]    <= 1'b0;
                outl[i]    <= 1'b1;
              end else if (dtc_r[i] == DT_ZERO) begin
                state_r[i] <= ST_HIGH;
                outh[i]    <= 1'b1;
                outl[i]    <= 1'b0;
              end else begin
                dtc_r[i] <= dtc_r[i] - DT_ONE;
                outh[i]  <= 1'b0;
                outl[i]  <= 1'b0;
              end
            end
            ST_HIGH: begin
              if (!raw_s[i] && dt_goal_r == DT_ZERO) begin
                state_r[i] <= ST_LOW;
                outh[i]    <= 1'b0;
                outl[i]    <= 1'b1;
              end else if (!raw_s[i]) begin
                state_r[i] <= ST_DEAD_F;
                dtc_r[i]   <= dt_goal_r - DT_ONE;
                outh[i]    <= 1'b0;
                outl[i]    <= 1'b0;
              end else begin
                outh[i] <= 1'b1;
                outl[i] <= 1'b0;
              end
            end
            ST_DEAD_F: begin
              if (raw_s[i]) begin
                state_r[i] <= ST_HIGH;
                outh[i]    <= 1'b1;
                outl[i]    <= 1'b0;
              end else if (dtc_r[i] == DT_ZERO) begin
                state_r[i] <= ST_LOW;
                outh[i]    <= 1'b0;
                outl[i]    <= 1'b1;
              end else begin
                dtc_r[i] <= dtc_r[i] - DT_ONE;
                outh[i]  <= 1'b0;
                outl[i]  <= 1'b0;
              end
            end
            default: begin
              state_r[i] <= ST_OFF;
              outh[i]    <= 1'b0;
              outl[i]    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_output.sv
// Scoreboard bench for pwm_deadtime_output at WIDTH=4, CHANNELS=2: expected gate
// patterns come from a per-phase formula of counter value, duty and dead time.
module tb_pwm_deadtime_output;
  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int DTW  = 6;
  localparam int MAXC = (1 << W) - 1;
  localparam int EPER = 1 << W;
  localparam int CPER = 2 * (1 << W) - 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          center_mode;
  logic [CH*W-1:0] set;
  logic [DTW-1:0]  deadtime;
  logic [CH-1:0]   outh;
  logic [CH-1:0]   outl;
  logic            period_start;

  pwm_deadtime_output #(.WIDTH(W), .CHANNELS(CH), .DT_WIDTH(DTW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .center_mode(center_mode),
    .set(set), .deadtime(deadtime), .outh(outh), .outl(outl),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] h;
    logic [CH-1:0] l;
    logic          ps;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  // model state: k = index of the counter value before the next edge
  int k;
  int g_act[CH];
  int d_act;
  bit m_act;
  int s_v[CH];
  int dt_v;
  bit cm_v;

  // steady-state {outh,outl} for the cycle after the counter showed c
  function automatic logic [1:0] exp_ch(int c, int s, int d);
    if (c < s) return (c < d) ? 2'b00 : 2'b10;
    else if (s > d && c < s + d) return 2'b00;
    else return 2'b01;
  endfunction

  task automatic drive(int s1, int s0, int dt, bit cm);
    set         = {s1[W-1:0], s0[W-1:0]};
    deadtime    = dt[DTW-1:0];
    center_mode = cm;
    s_v[1] = s1;
    s_v[0] = s0;
    dt_v   = dt;
    cm_v   = cm;
  endtask

  task automatic push(logic [CH-1:0] h, logic [CH-1:0] l, logic ps, string tag);
    exp_t e;
    e.h = h; e.l = l; e.ps = ps; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    e = exp_q.pop_front();
    chk_cnt++;
    assert ({outh, outl, period_start} === {e.h, e.l, e.ps}) pass_cnt++;
    else $error("FAIL %s: observed h/l/ps=%b/%b/%b expected %b/%b/%b",
                e.tag, outh, outl, period_start, e.h, e.l, e.ps);
    chk_cnt++;
    assert ((outh & outl) === 2'b00) pass_cnt++;
    else $error("FAIL %s_overlap: observed outh&outl=%b expected 00", e.tag, outh & outl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic step_exp(logic [CH-1:0] h, logic [CH-1:0] l, logic ps, string tag);
    push(h, l, ps, tag);
    tick();
  endtask

  task automatic cyc(bit chk, string tag);
    int c;
    logic [CH-1:0] h;
    logic [CH-1:0] l;
    logic ps;
    c  = m_act ? ((k <= MAXC) ? k : CPER - k) : k;
    ps = (k == 0);
    for (int ch = 0; ch < CH; ch++) {h[ch], l[ch]} = exp_ch(c, g_act[ch], d_act);
    if (k == 0) begin
      g_act = s_v;
      d_act = dt_v;
      m_act = cm_v;
    end
    if (chk) step_exp(h, l, ps, tag);
    else begin
      @(posedge clk);
      #1;
    end
    k = (k + 1) % (m_act ? CPER : EPER);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    drive(0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push(2'b00, 2'b00, 1'b0, "reset");
    sample();

    #4;
    reset_n = 1'b1;
    enable  = 1'b1;
    drive(8, 8, 0, 1'b0);
    step_exp(2'b00, 2'b11, 1'b1, "first_low");
    k = 1; g_act = s_v; d_act = 0; m_act = 1'b0;
    repeat (31) cyc(1'b1, "edge_dt0");

    drive(8, 8, 2, 1'b0);
    repeat (16) cyc(1'b0, "");
    repeat (16) cyc(1'b1, "edge_dt2");

    drive(2, 2, 3, 1'b0);
    repeat (16) cyc(1'b0, "");
    repeat (16) cyc(1'b1, "swallow");

    drive(8, 8, 0, 1'b0);
    repeat (16) cyc(1'b0, "");
    repeat (5) cyc(1'b1, "upd_old");
    drive(4, 4, 0, 1'b0);
    repeat (27) cyc(1'b1, "upd_new");

    drive(5, 5, 0, 1'b1);
    repeat (60) cyc(1'b1, "center");

    drive(12, 3, 1, 1'b0);
    repeat (16) cyc(1'b0, "");
    repeat (22) cyc(1'b1, "two_ch");

    enable = 1'b0;
    step_exp(2'b00, 2'b00, 1'b0, "disable");
    repeat (3) step_exp(2'b00, 2'b00, 1'b0, "disabled");
    enable = 1'b1;
    step_exp(2'b00, 2'b11, 1'b1, "reen_low");
    step_exp(2'b00, 2'b00, 1'b0, "reen_deadr");
    step_exp(2'b11, 2'b00, 1'b0, "reen_high");
    step_exp(2'b10, 2'b00, 1'b0, "reen_ch0_fall");

    #3;
    reset_n = 1'b0;
    #1;
    push(2'b00, 2'b00, 1'b0, "async_rst");
    sample();
    step_exp(2'b00, 2'b00, 1'b0, "in_rst");
    #4;
    reset_n = 1'b1;
    step_exp(2'b00, 2'b11, 1'b1, "rst_low");
    step_exp(2'b00, 2'b00, 1'b0, "rst_deadr");
    step_exp(2'b11, 2'b00, 1'b0, "rst_high");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
